// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: reset/stall levels,
// FSM state encoding and default stage indices.
package pipe_ctrl_pkg;

  // Signal levels
  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  // Flush sequencer states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Default stage indices for the 6-stage in-order core
  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

endpackage

// File: rtl/pipe_ctrl_stall_therm_enc.sv
// Request vector to thermometer stall vector: the highest requesting stage
// and every stage upstream of it are held. Purely combinational.
module stall_therm_enc
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE = 6
) (
  input  logic [NSTAGE-1:0] i_stallreq,
  output logic [NSTAGE-1:0] o_stall
);

  logic w_seen;

  // Scan from WB down to PC; once a request is seen all lower stages hold
  always_comb begin
    w_seen  = NO_STOP;
    o_stall = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      w_seen     = w_seen | (i_stallreq[i] == STOP);
      o_stall[i] = w_seen;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: thermometer stall vector, multi-cycle flush
// sequencer with redirect PC, saturating stall-cycle counter.
// Optional stall watchdog compiled in with PIPE_CTRL_STALL_WDT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NSTAGE    = 6,
  parameter int unsigned AW        = 32,
  parameter int unsigned FLUSH_LEN = 1,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned WDT_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              flushreq,
  input  logic [AW-1:0]     handler_pc,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [AW-1:0]     new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              wdt_timeout
);

  // Remaining-cycle counter only needs to hold FLUSH_LEN-1
  localparam int unsigned REM_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [REM_W-1:0]   r_rem;
  logic [REM_W-1:0]   w_rem_nxt;
  logic [AW-1:0]      r_pc_q;
  logic [AW-1:0]      w_pc_nxt;
  logic [NSTAGE-1:0]  w_therm;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               w_rst_act;

  assign w_rst_act = (rst == RST_ENABLE);

  stall_therm_enc #(
    .NSTAGE (NSTAGE)
  ) u_therm (
    .i_stallreq (stallreq),
    .o_stall    (w_therm)
  );

  // Flush sequencer state, remaining count and captured redirect PC
  always_ff @(posedge clk) begin
    if (w_rst_act) begin
      r_state <= ST_RUN;
      r_rem   <= '0;
      r_pc_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_pc_q  <= w_pc_nxt;
    end
  end

  // Next state and zero-latency stall/flush/redirect outputs
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_pc_nxt    = r_pc_q;
    stall       = '0;
    flush       = 1'b0;
    new_pc      = '0;
    case (r_state)
      ST_RUN: begin
        if (flushreq) begin
          flush    = 1'b1;
          new_pc   = handler_pc;
          w_pc_nxt = handler_pc;
          if (FLUSH_LEN > 1) begin
            w_state_nxt = ST_FLUSH;
            w_rem_nxt   = REM_W'(FLUSH_LEN - 1);
          end
        end else begin
          stall = w_therm;
        end
      end
      ST_FLUSH: begin
        flush     = 1'b1;
        new_pc    = r_pc_q;
        w_rem_nxt = r_rem - REM_W'(1);
        if (r_rem == REM_W'(1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
    // Outputs stay quiet for the whole reset cycle
    if (w_rst_act) begin
      stall  = '0;
      flush  = 1'b0;
      new_pc = '0;
    end
  end

  // Saturating count of cycles where any stage is held
  always_ff @(posedge clk) begin
    if (w_rst_act) begin
      r_stall_cnt <= '0;
    end else if ((|stall) && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;

`ifdef PIPE_CTRL_STALL_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_LIMIT + 1);

  logic [WDT_W-1:0] r_streak;
  logic             r_wdt;

  // Consecutive-stall streak (saturates at the limit) and sticky trip flag
  always_ff @(posedge clk) begin
    if (w_rst_act) begin
      r_streak <= '0;
      r_wdt    <= 1'b0;
    end else begin
      if (r_streak == WDT_W'(WDT_LIMIT)) begin
        r_wdt <= 1'b1;
      end
      if (!(|stall) || flush) begin
        r_streak <= '0;
      end else if (r_streak != WDT_W'(WDT_LIMIT)) begin
        r_streak <= r_streak + WDT_W'(1);
      end
    end
  end

  assign wdt_timeout = r_wdt;
`else
  assign wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (FLUSH_LEN=3/CNT_W=4 and
// FLUSH_LEN=1/CNT_W=32) share stimulus; a table of directed vectors,
// hand sequences and random cycles are checked against a reference model.
module tb_pipe_ctrl;

  localparam int unsigned LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic        flushreq;
  logic [31:0] handler_pc;

  logic [5:0]  stall0, stall1;
  logic        flush0, flush1;
  logic [31:0] npc0, npc1;
  logic [3:0]  cnt0;
  logic [31:0] cnt1;
  logic        wdt0, wdt1;

  always #5 clk = ~clk;

  pipe_ctrl #(.NSTAGE(6), .AW(32), .FLUSH_LEN(3), .CNT_W(4), .WDT_LIMIT(LIM)) u_dut0 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flushreq(flushreq),
    .handler_pc(handler_pc), .stall(stall0), .flush(flush0), .new_pc(npc0),
    .stall_cycles(cnt0), .wdt_timeout(wdt0)
  );

  pipe_ctrl #(.NSTAGE(6), .AW(32), .FLUSH_LEN(1), .CNT_W(32), .WDT_LIMIT(LIM)) u_dut1 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flushreq(flushreq),
    .handler_pc(handler_pc), .stall(stall1), .flush(flush1), .new_pc(npc1),
    .stall_cycles(cnt1), .wdt_timeout(wdt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: flush cycles still owed, captured PC, counters
  int          m_left   [2];
  longint      m_cnt    [2];
  int          m_streak [2];
  bit          m_wdt    [2];
  logic [31:0] m_pc     [2];

  function automatic int flen(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic longint cmax(input int d);
    return (d == 0) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  function automatic logic [5:0] therm(input logic [5:0] r);
    int k;
    k = -1;
    for (int i = 0; i < 6; i++) if (r[i]) k = i;
    if (k < 0) return 6'd0;
    return 6'((1 << (k + 1)) - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input int d, output logic [5:0] es, output logic ef,
                            output logic [31:0] ep);
    es = '0; ef = 1'b0; ep = '0;
    if (rst !== 1'b1) begin
      if (m_left[d] > 0) begin
        ef = 1'b1; ep = m_pc[d];
      end else if (flushreq) begin
        ef = 1'b1; ep = handler_pc;
      end else begin
        es = therm(stallreq);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [5:0] es; logic ef; logic [31:0] ep; bit ew;
    for (int d = 0; d < 2; d++) begin
      expect_out(d, es, ef, ep);
`ifdef PIPE_CTRL_STALL_WDT_EN
      ew = m_wdt[d];
`else
      ew = 1'b0;
`endif
      chk($sformatf("%s.d%0d.stall", tag, d), 64'(d == 0 ? stall0 : stall1), 64'(es));
      chk($sformatf("%s.d%0d.flush", tag, d), 64'(d == 0 ? flush0 : flush1), 64'(ef));
      chk($sformatf("%s.d%0d.new_pc", tag, d), 64'(d == 0 ? npc0 : npc1), 64'(ep));
      chk($sformatf("%s.d%0d.cnt", tag, d), d == 0 ? 64'(cnt0) : 64'(cnt1), 64'(m_cnt[d]));
      chk($sformatf("%s.d%0d.wdt", tag, d), 64'(d == 0 ? wdt0 : wdt1), 64'(ew));
    end
  endtask

  task automatic model_edge();
    logic [5:0] es; logic ef; logic [31:0] ep;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_left[d] = 0; m_cnt[d] = 0; m_streak[d] = 0; m_wdt[d] = 1'b0;
      end else begin
        expect_out(d, es, ef, ep);
        if (es != 0 && m_cnt[d] < cmax(d)) m_cnt[d]++;
        if (m_streak[d] >= int'(LIM)) m_wdt[d] = 1'b1;
        if (es != 0 && !ef) m_streak[d] = (m_streak[d] < int'(LIM)) ? m_streak[d] + 1 : m_streak[d];
        else m_streak[d] = 0;
        if (m_left[d] > 0) m_left[d]--;
        else if (flushreq) begin
          m_pc[d] = handler_pc;
          m_left[d] = flen(d) - 1;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] sr, input logic fr, input logic [31:0] pc);
    rst = r; stallreq = sr; flushreq = fr; handler_pc = pc;
  endtask

  task automatic cycle(input logic r, input logic [5:0] sr, input logic fr,
                       input logic [31:0] pc, input bit do_chk, input string tag);
    drive(r, sr, fr, pc);
    #4;
    if (do_chk) check_all(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [5:0]  sr;
    logic        fr;
    logic [31:0] pc;
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    logic [3:0]  ec;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [5:0] sr, input logic fr,
                              input logic [31:0] pc, input logic [5:0] es,
                              input logic ef, input logic [31:0] ep, input logic [3:0] ec);
    vec_t v;
    v.r = r; v.sr = sr; v.fr = fr; v.pc = pc; v.es = es; v.ef = ef; v.ep = ep; v.ec = ec;
    return v;
  endfunction

  vec_t tbl [20];
`ifdef PIPE_CTRL_STALL_WDT_EN
  localparam logic WDT_EXP = 1'b1;
`else
  localparam logic WDT_EXP = 1'b0;
`endif

  initial begin
    // Directed vectors for the FLUSH_LEN=3 / CNT_W=4 instance
    tbl[0]  = mk(1, 6'b001100, 1, 32'h140, 6'b000000, 0, 32'h0,   4'd0);
    tbl[1]  = mk(0, 6'b001100, 0, 32'h0,   6'b001111, 0, 32'h0,   4'd0);
    tbl[2]  = mk(0, 6'b000100, 0, 32'h0,   6'b000111, 0, 32'h0,   4'd1);
    tbl[3]  = mk(1, 6'b000000, 0, 32'h0,   6'b000000, 0, 32'h0,   4'd2);
    tbl[4]  = mk(0, 6'b101000, 0, 32'h0,   6'b111111, 0, 32'h0,   4'd0);
    tbl[5]  = mk(0, 6'b101000, 0, 32'h0,   6'b111111, 0, 32'h0,   4'd1);
    tbl[6]  = mk(0, 6'b101000, 0, 32'h0,   6'b111111, 0, 32'h0,   4'd2);
    tbl[7]  = mk(0, 6'b101000, 0, 32'h0,   6'b111111, 0, 32'h0,   4'd3);
    tbl[8]  = mk(0, 6'b101000, 0, 32'h0,   6'b111111, 0, 32'h0,   4'd4);
    tbl[9]  = mk(0, 6'b001000, 1, 32'h140, 6'b000000, 1, 32'h140, 4'd5);
    tbl[10] = mk(0, 6'b001000, 1, 32'h200, 6'b000000, 1, 32'h140, 4'd5);
    tbl[11] = mk(0, 6'b001000, 0, 32'h0,   6'b000000, 1, 32'h140, 4'd5);
    tbl[12] = mk(0, 6'b001000, 0, 32'h0,   6'b001111, 0, 32'h0,   4'd5);
    tbl[13] = mk(0, 6'b000000, 1, 32'h300, 6'b000000, 1, 32'h300, 4'd6);
    tbl[14] = mk(0, 6'b000000, 1, 32'h300, 6'b000000, 1, 32'h300, 4'd6);
    tbl[15] = mk(0, 6'b000000, 1, 32'h400, 6'b000000, 1, 32'h300, 4'd6);
    tbl[16] = mk(0, 6'b000000, 1, 32'h400, 6'b000000, 1, 32'h400, 4'd6);
    tbl[17] = mk(1, 6'b000001, 0, 32'h0,   6'b000000, 0, 32'h0,   4'd6);
    tbl[18] = mk(0, 6'b000001, 0, 32'h0,   6'b000001, 0, 32'h0,   4'd0);
    tbl[19] = mk(0, 6'b000000, 0, 32'h0,   6'b000000, 0, 32'h0,   4'd1);

    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_cnt[d] = 0; m_streak[d] = 0; m_wdt[d] = 1'b0; m_pc[d] = '0;
    end

    // Bring registers out of X before any check
    cycle(1, 6'b0, 0, 32'h0, 0, "init");
    cycle(1, 6'b0, 0, 32'h0, 0, "init");

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, tbl[i].sr, tbl[i].fr, tbl[i].pc);
      #4;
      chk($sformatf("tbl%0d.stall", i), 64'(stall0), 64'(tbl[i].es));
      chk($sformatf("tbl%0d.flush", i), 64'(flush0), 64'(tbl[i].ef));
      chk($sformatf("tbl%0d.new_pc", i), 64'(npc0), 64'(tbl[i].ep));
      chk($sformatf("tbl%0d.cnt", i), 64'(cnt0), 64'(tbl[i].ec));
      check_all($sformatf("tbl%0d", i));
      model_edge();
      @(posedge clk);
      #1;
    end

    // Saturation: 20 consecutive stalls on the 4-bit counter
    cycle(1, 6'b0, 0, 32'h0, 1, "sat.rst");
    for (int i = 0; i < 20; i++) cycle(0, 6'b000010, 0, 32'h0, 1, "sat");
    chk("sat.cnt_full", 64'(cnt0), 64'hF);
    cycle(0, 6'b000010, 0, 32'h0, 1, "sat.hold");
    chk("sat.cnt_hold", 64'(cnt0), 64'hF);
    chk("sat.cnt_wide", 64'(cnt1), 64'd21);

    // Watchdog: 8 consecutive stalls trip it one edge later, sticky
    cycle(1, 6'b0, 0, 32'h0, 1, "wdt.rst");
    for (int i = 0; i < 8; i++) cycle(0, 6'b000001, 0, 32'h0, 1, "wdt.run");
    chk("wdt.before_trip", 64'(wdt0), 64'd0);
    cycle(0, 6'b000000, 0, 32'h0, 1, "wdt.idle");
    chk("wdt.trip", 64'(wdt0), 64'(WDT_EXP));
    for (int i = 0; i < 3; i++) cycle(0, 6'b000000, 0, 32'h0, 1, "wdt.idle");
    chk("wdt.sticky", 64'(wdt0), 64'(WDT_EXP));

    // Watchdog: 7 stalls, gap, 7 stalls never trips
    cycle(1, 6'b0, 0, 32'h0, 1, "wdt2.rst");
    for (int i = 0; i < 7; i++) cycle(0, 6'b000100, 0, 32'h0, 1, "wdt2.a");
    cycle(0, 6'b000000, 0, 32'h0, 1, "wdt2.gap");
    for (int i = 0; i < 7; i++) cycle(0, 6'b000100, 0, 32'h0, 1, "wdt2.b");
    for (int i = 0; i < 2; i++) cycle(0, 6'b000000, 0, 32'h0, 1, "wdt2.idle");
    chk("wdt2.no_trip", 64'(wdt0), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] sr;
      sr = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, sr,
            ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, $urandom, 1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
